apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 8, APB address width.
REQ-002 The block SHALL expose parameter DATA_W, default 32, APB data width.
REQ-003 The block SHALL expose parameter TIMEOUT_CYCLES, default 16, the ACCESS-phase wait-state limit, range 2..255.
REQ-004 PCLK  input  1  APB clock; all logic on the rising edge.
REQ-005 PRESET  input  1  reset; asynchronous, active-low.
REQ-006 cmd_valid  input  1  a command is offered.
REQ-007 cmd_ready  output  1  the master accepts a command this cycle.
REQ-008 cmd_write  input  1  1=write, 0=read.
REQ-009 cmd_addr  input  ADDR_W  target address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_W  read data; 0 for writes and aborts.
REQ-013 rsp_err  output  1  transfer aborted by timeout; qualified by rsp_valid.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  APB requester controls.
REQ-015 PADDR  output  ADDR_W;  PWDATA  output  DATA_W;  PRDATA  input  DATA_W;  PREADY  input  1.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP and ACCESS; all APB and rsp outputs SHALL be registered.
REQ-017 cmd_ready SHALL be 1 exactly when the state is IDLE.
REQ-018 At an edge with IDLE and cmd_valid=1: latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA, PSEL<=1, PENABLE<=0, go to SETUP.
REQ-019 SETUP SHALL last exactly one cycle, then PENABLE<=1 and go to ACCESS regardless of PREADY.
REQ-020 In ACCESS, PSEL/PENABLE/PADDR/PWRITE/PWDATA SHALL hold until completion; PADDR/PWRITE/PWDATA SHALL hold after completion until the next command.
REQ-021 At an edge in ACCESS with PREADY=1: PSEL<=0, PENABLE<=0, rsp_valid<=1, rsp_err<=0, rsp_rdata<=PRDATA for a read and 0 for a write, go to IDLE.
REQ-022 Zero-wait latency: command accepted at edge E0 -> SETUP after E0 -> ACCESS after E1 -> rsp_valid high for exactly the cycle after E2.
REQ-023 rsp_valid SHALL stay high for exactly one cycle; rsp_rdata and rsp_err SHALL hold until the next completion.
REQ-024 A command offered while rsp_valid=1 (state IDLE) SHALL be accepted in that cycle; no back-to-back SETUP without passing through IDLE.
REQ-025 cmd_valid outside IDLE SHALL be ignored; the command is not dropped, since cmd_ready=0.
REQ-026 PSEL=1 with PENABLE=0 SHALL never last more than one cycle.

Reset
REQ-027 PRESET low SHALL force IDLE and drive PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the timeout counter to 0, immediately.
REQ-028 Reset in SETUP or ACCESS SHALL abandon the transfer with no rsp_valid; the first edge after release SHALL see IDLE and cmd_ready=1.

Configuration
REQ-029 Macro APB_MASTER_TIMEOUT_EN, defined: an ACCESS wait counter SHALL clear on entering ACCESS and increment on each ACCESS edge with PREADY=0.
REQ-030 With the macro defined: when TIMEOUT_CYCLES ACCESS cycles have elapsed with PREADY=0, the block SHALL complete with rsp_valid=1, rsp_err=1, rsp_rdata=0, deassert PSEL/PENABLE and go to IDLE.
REQ-031 With the macro defined: PREADY=1 on the limit edge SHALL win, giving a normal completion with rsp_err=0.
REQ-032 Without the macro: no counter, ACCESS waits indefinitely, and rsp_err SHALL be constant 0.

Structure
REQ-033 Package apb_pkg SHALL hold the state encodings IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10 and the ADDR_W/DATA_W defaults shared with the APB slave.
REQ-034 The wait counter SHALL be sub-module apb_timeout_ctr, instantiated only under APB_MASTER_TIMEOUT_EN; the FSM and datapath SHALL stay in apb_master.

Verification
REQ-035 Write 0xDEADBEEF to 0x10 against the team APB slave -> PSEL then PENABLE, PADDR=0x10 stable through ACCESS, rsp_valid once, rsp_err=0, rsp_rdata=0.
REQ-036 Read 0x10 after REQ-035 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly one cycle.
REQ-037 Responder holds PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 -> all APB outputs stable, completion one cycle after PREADY is sampled high, rsp_rdata=0x12345678.
REQ-038 Macro defined, TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles with rsp_err=1 and rsp_rdata=0; PREADY rising on the 4th edge -> rsp_err=0.
REQ-039 cmd_valid held high for 3 commands -> each command accepted in the IDLE cycle coincident with the previous rsp_valid; 3 cycles per transfer; no command lost or duplicated.
REQ-040 PRESET asserted mid-ACCESS -> all outputs 0 immediately, no rsp_valid, cmd_ready=1 at the first post-release edge.

Source files
------------

// File: rtl/apb_pkg.sv
// APB shared definitions: FSM state encodings and the default bus widths
// used by both the APB master and the team APB slave.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    // Width of the ACCESS-phase wait counter (covers limits up to 255).
    localparam int TMO_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter for apb_master. Cleared when the master enters
// ACCESS, advanced on every ACCESS edge that sees PREADY low. 'expired' is
// high while the counter sits at LIMIT-1, i.e. the current ACCESS edge is
// the LIMIT-th one without PREADY.
module apb_timeout_ctr
    import apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] count;

    // Count waited ACCESS cycles; saturate at the last value.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB transfer
// (IDLE -> SETUP -> ACCESS) and returns a one-cycle response pulse.
// Optional feature macro: APB_MASTER_TIMEOUT_EN -- aborts an ACCESS phase
// that waits TIMEOUT_CYCLES cycles without PREADY (rsp_err=1).
//
// Handshake: a command transfers on a rising edge where cmd_valid=1 and
// cmd_ready=1. cmd_ready is high exactly in IDLE; the offering side must
// hold cmd_* stable until that edge. rsp_valid is a one-cycle pulse with no
// back-pressure; rsp_rdata/rsp_err hold until the next completion.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic [1:0]        state_dbg
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be in 2..255");
    end

    apb_state_e state;
    logic       timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    logic tmo_expired;

    apb_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .clear  (state == SETUP),
        .inc    ((state == ACCESS) && !PREADY),
        .expired(tmo_expired)
    );

    assign timeout_hit = tmo_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign state_dbg = state;

    // Transfer FSM with all APB and response outputs registered.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR   <= cmd_addr;
                        PWRITE  <= cmd_write;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    // SETUP is always exactly one cycle.
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout on the same edge.
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        state     <= IDLE;
                    end else if (timeout_hit) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small APB responder model and a
// response scoreboard. Outputs are sampled on the falling clock edge.
module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [1:0]  state_dbg;

    apb_master #(
        .ADDR_W(8),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- APB responder model ----------------
    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    int          wait_states = 0;
    bit          hang = 1'b0;
    int          wcnt = 0;

    // Drive PREADY/PRDATA for the next edge: wait_states low cycles, then ready.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (!hang && wcnt >= wait_states) begin
                PREADY = 1'b1;
            end else begin
                PREADY = 1'b0;
                wcnt++;
            end
            PRDATA = mem[PADDR];
        end else begin
            PREADY = 1'b0;
            PRDATA = 32'h0;
            wcnt   = 0;
        end
    end

    // Slave register write on a completed write transfer.
    always @(posedge PCLK) begin
        if (PRESET && PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];

    // Every response pulse must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        if (PRESET && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rsp", rsp_valid, 1'b0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("sb_rdata", rsp_rdata, e[31:0]);
                chk("sb_err", rsp_err, e[32]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                            input logic err);
        logic [31:0] rd;
        rd = (err || wr) ? 32'h0 : shadow[addr];
        exp_q.push_back({err, rd});
        if (wr && !err) shadow[addr] = data;
    endtask

    // One command from an idle negedge; checks phases, stability and latency.
    task automatic do_cmd(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [31:0] data, input int exp_lat, input logic exp_err);
        int lat;
        logic [31:0] exp_rd;
        exp_rd = (exp_err || wr) ? 32'h0 : shadow[addr];
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        push_exp(wr, addr, data, exp_err);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_addr  = 8'hFF;
        lat = 1;
        chk({tag, "_setup"}, {PSEL, PENABLE, cmd_ready}, 3'b100);
        while (!rsp_valid && lat < 200) begin
            @(negedge PCLK);
            lat++;
            if (!rsp_valid) begin
                chk({tag, "_access"}, {PSEL, PENABLE}, 2'b11);
                chk({tag, "_paddr"}, PADDR, addr);
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_done_idle"}, {PSEL, PENABLE, cmd_ready}, 3'b001);
        chk({tag, "_pwrite_hold"}, {PWRITE, PADDR}, {wr, addr});
        @(negedge PCLK);
        chk({tag, "_pulse_1cyc"}, rsp_valid, 1'b0);
        chk({tag, "_rdata_hold"}, {rsp_err, rsp_rdata}, {exp_err, exp_rd});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit expired");
    end

    // ---------------- directed sequence ----------------
    logic [7:0]  b_addr [3];
    logic [31:0] b_data [3];
    logic        b_wr   [3];

    initial begin
        int last;
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        PRESET    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h0;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        PRDATA    = 32'h0;

        // Reset state.
        @(negedge PCLK);
        @(negedge PCLK);
        chk("rst_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 43'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        chk("rst_ready_state", {cmd_ready, state_dbg}, 3'b100);
        PRESET = 1'b1;
        @(negedge PCLK);

        // Zero-wait write then read back.
        do_cmd("wr_10", 1'b1, 8'h10, 32'hDEADBEEF, 3, 1'b0);
        do_cmd("rd_10", 1'b0, 8'h10, 32'h0, 3, 1'b0);

        // Read with three wait states.
        do_cmd("wr_20", 1'b1, 8'h20, 32'h12345678, 3, 1'b0);
        wait_states = 3;
        do_cmd("rd_20_wait3", 1'b0, 8'h20, 32'h0, 6, 1'b0);

        // Random writes/reads with random wait states.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] a;
            a = 8'h40 + 8'($urandom_range(0, 3));
            wait_states = $urandom_range(0, 3);
            do_cmd("rand_wr", 1'b1, a, $urandom, 3 + wait_states, 1'b0);
            wait_states = $urandom_range(0, 3);
            do_cmd("rand_rd", 1'b0, a, 32'h0, 3 + wait_states, 1'b0);
        end

        // Back-to-back commands with cmd_valid held high.
        wait_states = 0;
        b_wr[0] = 1'b1; b_addr[0] = 8'h30; b_data[0] = 32'hAAAA5555;
        b_wr[1] = 1'b0; b_addr[1] = 8'h30; b_data[1] = 32'h0;
        b_wr[2] = 1'b1; b_addr[2] = 8'h31; b_data[2] = 32'h0F0F0F0F;
        last = 0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_write = b_wr[k];
            cmd_addr  = b_addr[k];
            cmd_wdata = b_data[k];
            n = 0;
            while (!cmd_ready && n < 20) begin
                @(negedge PCLK);
                n++;
            end
            chk("b2b_ready", cmd_ready, 1'b1);
            if (k > 0) begin
                chk("b2b_rsp_coincide", rsp_valid, 1'b1);
                chk("b2b_gap", cyc - last, 3);
            end
            last = cyc;
            push_exp(b_wr[k], b_addr[k], b_data[k], 1'b0);
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("b2b_drained", exp_q.size(), 0);
        @(negedge PCLK);
        do_cmd("b2b_rd_31", 1'b0, 8'h31, 32'h0, 3, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
        // PREADY never comes: abort after TMO ACCESS cycles.
        hang = 1'b1;
        do_cmd("tmo_abort", 1'b0, 8'h10, 32'h0, TMO + 2, 1'b1);
        hang = 1'b0;
        // PREADY rises on the limit edge: normal completion.
        wait_states = TMO - 1;
        do_cmd("tmo_edge_ready", 1'b0, 8'h10, 32'h0, TMO + 2, 1'b0);
`else
        // Without the timeout the master waits as long as the slave stalls.
        wait_states = 20;
        do_cmd("long_wait", 1'b0, 8'h10, 32'h0, 23, 1'b0);
`endif

        // Reset asserted mid-ACCESS abandons the transfer.
        wait_states = 10;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        push_exp(1'b0, 8'h20, 32'h0, 1'b0);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("rstmid_in_access", {PSEL, PENABLE, state_dbg}, 4'b1110);
        #2;
        PRESET = 1'b0;
        #1;
        chk("rstmid_apb_zero", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 43'h0);
        chk("rstmid_rsp_zero", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        chk("rstmid_ready", cmd_ready, 1'b1);
        chk("rstmid_pending", exp_q.size(), 1);
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge PCLK);
            chk("rstmid_no_rsp", rsp_valid, 1'b0);
        end
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        chk("rstmid_post_release", {cmd_ready, state_dbg, rsp_valid, PSEL}, 5'b10000);
        @(negedge PCLK);
        wait_states = 0;
        do_cmd("post_rst_rd", 1'b0, 8'h10, 32'h0, 3, 1'b0);

        chk("sb_empty_at_end", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
